seq_alu_core: RTL

// - Parametrised, handshaked, multi-cycle ALU. Successor to the combinational 4-bit ALU.
// - Accepts one operation per valid/ready transfer.
// - Single-cycle ops are registered. MUL/DIV run iteratively (shift-add / restoring).
// - Drives a registered result plus flags to the board display/register-select logic.

---
 rtl/seq_alu_core_if.sv | 45 ++++
 rtl/seq_alu_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_core_if.sv
// ============================================================================
// Module   : seq_alu_core_if
// Purpose  : Handshake bundle for seq_alu_core. It carries an operand channel
//            (valid/ready, a, b, op) and a result channel (valid/ready,
//            result and flags).
// Ports    : master - the producer of operations and consumer of results
//            slave  - the ALU core
//   in_valid/in_ready     operand transfer handshake
//   a, b [WIDTH]          unsigned operands
//   op [4]                opcode
//   out_valid/out_ready   result transfer handshake
//   result [2*WIDTH]      result value
//   carry, zero           ADD carry / SUB borrow, result-is-zero
//   div_by_zero           DIV was issued with b == 0
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_alu_core_if #(
  parameter int WIDTH = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           op;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 carry;
  logic                 zero;
  logic                 div_by_zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, zero, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_alu_core.sv
// ============================================================================
// Module   : seq_alu_core
// Purpose  : Handshaked multi-cycle ALU. Single-cycle ops are computed at the
//            accept edge. MUL (shift-add) and DIV (restoring) each take one
//            iteration per clock for WIDTH clocks. The result and flags are
//            registered and held until the consumer takes them.
// Ports    : clk    - system clock, rising edge
//            rst_n  - synchronous reset, active-low
//            bus    - seq_alu_core_if.slave (operand and result channels)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_core #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_alu_core_if.slave bus
);

  localparam logic [3:0] c_OP_ADD  = 4'h0;
  localparam logic [3:0] c_OP_SUB  = 4'h1;
  localparam logic [3:0] c_OP_MUL  = 4'h2;
  localparam logic [3:0] c_OP_DIV  = 4'h3;
  localparam logic [3:0] c_OP_SHL  = 4'h4;
  localparam logic [3:0] c_OP_SHR  = 4'h5;
  localparam logic [3:0] c_OP_ROL  = 4'h6;
  localparam logic [3:0] c_OP_ROR  = 4'h7;
  localparam logic [3:0] c_OP_AND  = 4'h8;
  localparam logic [3:0] c_OP_OR   = 4'h9;
  localparam logic [3:0] c_OP_XOR  = 4'hA;
  localparam logic [3:0] c_OP_NOR  = 4'hB;
  localparam logic [3:0] c_OP_NAND = 4'hC;
  localparam logic [3:0] c_OP_XNOR = 4'hD;
  localparam logic [3:0] c_OP_GT   = 4'hE;
  localparam logic [3:0] c_OP_EQ   = 4'hF;

  localparam int              c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_op_iter;
  logic                 w_div0;

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_sc_result;
  logic                 w_sc_carry;

  // Iterative datapath
  logic [c_CW-1:0]      r_cnt;
  logic                 r_is_div;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quot;
  logic [WIDTH-1:0]     r_divisor;

  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_trial;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_quot_nxt;
  logic [2*WIDTH-1:0]   w_iter_result;

  // Output registers
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_carry;
  logic                 r_zero;
  logic                 r_dbz;

  // in_ready is gated by rst_n so that it reads 0 for the whole reset window,
  // not only until the first reset edge has forced the state to IDLE.
  assign w_in_ready = rst_n && (r_state == S_IDLE);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_op_iter  = (bus.op == c_OP_MUL) || (bus.op == c_OP_DIV);
  assign w_div0     = (bus.op == c_OP_DIV) && (bus.b == '0);

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.result      = r_result;
  assign bus.carry       = r_carry;
  assign bus.zero        = r_zero;
  assign bus.div_by_zero = r_dbz;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Divide-by-zero has a fixed answer, so it bypasses the iterations.
          w_state_nxt = (w_op_iter && !w_div0) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------- single-cycle ops
  assign w_sum = {1'b0, bus.a} + {1'b0, bus.b};

  always_comb begin
    w_sc_result = '0;
    w_sc_carry  = 1'b0;
    case (bus.op)
      c_OP_ADD: begin
        w_sc_result = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        w_sc_carry  = w_sum[WIDTH];
      end
      c_OP_SUB: begin
        w_sc_result = {{WIDTH{1'b0}}, bus.a - bus.b};
        w_sc_carry  = (bus.a < bus.b);
      end
      c_OP_SHL:  w_sc_result = {{WIDTH{1'b0}}, bus.a[WIDTH-2:0], 1'b0};
      c_OP_SHR:  w_sc_result = {{WIDTH{1'b0}}, 1'b0, bus.a[WIDTH-1:1]};
      c_OP_ROL:  w_sc_result = {{WIDTH{1'b0}}, bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
      c_OP_ROR:  w_sc_result = {{WIDTH{1'b0}}, bus.a[0], bus.a[WIDTH-1:1]};
      c_OP_AND:  w_sc_result = {{WIDTH{1'b0}}, bus.a & bus.b};
      c_OP_OR:   w_sc_result = {{WIDTH{1'b0}}, bus.a | bus.b};
      c_OP_XOR:  w_sc_result = {{WIDTH{1'b0}}, bus.a ^ bus.b};
      c_OP_NOR:  w_sc_result = {{WIDTH{1'b0}}, ~(bus.a | bus.b)};
      c_OP_NAND: w_sc_result = {{WIDTH{1'b0}}, ~(bus.a & bus.b)};
      c_OP_XNOR: w_sc_result = {{WIDTH{1'b0}}, ~(bus.a ^ bus.b)};
      c_OP_GT:   w_sc_result = {{(2*WIDTH-1){1'b0}}, (bus.a > bus.b)};
      c_OP_EQ:   w_sc_result = {{(2*WIDTH-1){1'b0}}, (bus.a == bus.b)};
      default:   w_sc_result = '0;  // MUL/DIV go through the iterative path
    endcase
  end

  // ------------------------------------------------ iterative MUL / DIV
  // Shift-add multiply: add the shifted multiplicand whenever the current
  // multiplier LSB is set.
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Restoring divide: shift the next dividend bit into the partial
  // remainder and keep the trial subtraction only if it did not borrow.
  // The partial remainder stays below the divisor, so the shifted value is
  // below twice the divisor and bit WIDTH of the trial is a clean borrow.
  assign w_rem_sh      = {r_rem, r_quot[WIDTH-1]};
  assign w_trial       = w_rem_sh - {1'b0, r_divisor};
  assign w_ge          = ~w_trial[WIDTH];
  assign w_rem_nxt     = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quot_nxt    = {r_quot[WIDTH-2:0], w_ge};
  assign w_iter_result = r_is_div ? {w_rem_nxt, w_quot_nxt} : w_acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      // All operands are captured here; BUSY never looks at the bus again.
      r_cnt     <= '0;
      r_is_div  <= (bus.op == c_OP_DIV);
      r_acc     <= '0;
      r_mcand   <= {{WIDTH{1'b0}}, bus.a};
      r_mplier  <= bus.b;
      r_rem     <= '0;
      r_quot    <= bus.a;
      r_divisor <= bus.b;
      r_dbz     <= w_div0;
      if (w_div0) begin
        r_result <= {bus.a, {WIDTH{1'b1}}};
        r_carry  <= 1'b0;
        r_zero   <= 1'b0;  // the all-ones low half is never zero
      end else if (!w_op_iter) begin
        r_result <= w_sc_result;
        r_carry  <= w_sc_carry;
        r_zero   <= (w_sc_result == '0);
      end
    end else if (r_state == S_BUSY) begin
      r_cnt    <= r_cnt + c_CW'(1);
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_rem    <= w_rem_nxt;
      r_quot   <= w_quot_nxt;
      if (r_cnt == c_LAST) begin
        r_result <= w_iter_result;
        r_carry  <= 1'b0;
        r_zero   <= (w_iter_result == '0);
      end
    end
  end

endmodule

`default_nettype wire
